mips_mc_controller: RTL and testbench
=====================================

# mips_mc_controller

Control FSM for the multi-cycle MIPS datapath. Consumes `Op`, `Function` and `Zero` from the datapath and drives every datapath control strobe, sequencing each instruction through the fetch/decode/execute/memory/writeback steps. Also flags unsupported encodings, halts on them, and counts retired instructions.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: system clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-low. The top level drives the datapath's own reset from the same source.
- `Op` in 6: instruction opcode (IR[31:26]).
- `Function` in 6: R-type funct (IR[5:0]).
- `Zero` in 1: combinational ALUResult==0.
- `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `ALUSrcA`, `RegWrite`, `RegDst`, `PCSel` out 1 each: datapath strobes.
- `PCSource` out 2: 00 ALUResult, 01 ALUOut, 10 jump target.
- `ALUSrcB` out 2: 00 B, 01 constant 1, 1x sign-extended imm.
- `ALUCtrl` out 4: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1100 nor, 1101 xor.
- `state` out 4: current FSM state (debug).
- `instr_done` out 1: one-cycle pulse in the last cycle of each instruction.
- `illegal` out 1: sticky; set on an unsupported op/funct.
- `retired` out RETIRE_W: count of completed instructions.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11, HALT 15.
- Defaults: every unlisted 1-bit output is 0, `PCSource`=00, `ALUSrcB`=00, `ALUCtrl`=0010.
- FETCH: MemRead, IRWrite, ALUSrcB=01, PCSel, PCSource=00 (PC<=PC+1). Next state is DECODE.
- DECODE: ALUSrcB=10, add. ALUOut latches the branch target PC+1+imm. Next state by Op:
  - 100011 (lw) and 101011 (sw) go to MEMADR.
  - 000000 (R-type) goes to RTEX.
  - 000100 (beq) and 000101 (bne) go to BRANCH.
  - 001000 (addi) and 001010 (slti) go to IMMEX.
  - 000010 (j) goes to JUMP.
  - Any other opcode goes to HALT.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD and MEMWB: hold ALUSrcA=1, ALUSrcB=10, add, IorD=1, MemRead=1. This keeps ALUOut (re-latched every cycle) and MemData stable.
  - MEMWB additionally asserts RegWrite, MemtoReg=1, RegDst=0.
- MEMWR: same ALU hold, plus IorD=1 and MemWrite=1.
- RTEX: ALUSrcA=1, ALUSrcB=00. ALUCtrl from Function:
  - 100000 add → 0010; 100010 sub → 0110.
  - 100100 and → 0000; 100101 or → 0001.
  - 100110 xor → 1101; 100111 nor → 1100; 101010 slt → 0111.
  - Any other funct goes to HALT instead of RTWB.
- RTWB: same ALU drive as RTEX, plus RegWrite and RegDst=1.
- IMMEX: ALUSrcA=1, ALUSrcB=10, ALUCtrl add (addi) or 0111 (slti).
- IMMWB: same ALU drive as IMMEX, plus RegWrite and RegDst=0.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSource=01. PCSel is `Zero` for beq and `~Zero` for bne.
- JUMP: PCSel, PCSource=10. The datapath's jump register was loaded at the end of DECODE.
- After MEMWB, MEMWR, RTWB, IMMWB, BRANCH and JUMP, the next state is FETCH.
- HALT: all strobes 0, `illegal`=1. HALT is terminal until reset.
- `retired` increments on every `instr_done` and wraps modulo 2^RETIRE_W.

## Timing
- Reset assertion (async): `state`=FETCH (0), all strobes 0, `ALUCtrl`=0010, `illegal`=0, `retired`=0, `instr_done`=0.
  - While reset is low, outputs are forced to these values; FETCH strobes are not driven.
- The first FETCH strobes appear in the first cycle after reset deasserts. Reset mid-instruction aborts it with no pending write and no count.
- Outputs are a combinational function of `state`, `Op`, `Function` and `Zero` only (Moore, except PCSel in BRANCH).
- Cycles per instruction: lw 5, sw 4, R-type 4, addi/slti 4, beq/bne 3, j 3.
- `instr_done` is high in MEMWB, MEMWR, RTWB, IMMWB, BRANCH and JUMP. `retired` updates on the edge ending that cycle.
- An illegal op is detected in DECODE and an illegal funct in RTEX. HALT is entered on the next edge, with no RegWrite, MemWrite or PCSel beyond the FETCH increment.

## Test plan
- Reset held low 3 cycles, then released: state=0, outputs at reset values; the first FETCH has MemRead=IRWrite=PCSel=1 and ALUSrcB=01.
- Program with lw r1,4(r0) then sw r1,8(r0), mem[4]=0xDEADBEEF: lw takes 5 cycles, sw takes 4; mem[8]=0xDEADBEEF; retired=2.
- add r3,r1,r2 with r1=5, r2=7, then sub r4,r3,r1: r3=12, r4=7; each instruction 4 cycles; ALUCtrl 0010 then 0110 in RTEX/RTWB.
- beq r1,r1,+3 at PC 0x80: PC=0x84 after 3 cycles. bne r1,r1,+3: PC=0x81.
- j 0x90 at PC 0x80: PC=0x90 after 3 cycles; instr_done pulses exactly once.
- Opcode 0x3F, or R-type funct 0x3F: enters HALT (state=15), illegal=1, no RegWrite/MemWrite asserted. A mid-HALT reset clears illegal and restarts at FETCH.

Source files
------------

// File: rtl/mips_mc_controller_if.sv
// rtl/mips_mc_controller_if.sv - control/status bundle between the multi-cycle controller and the MIPS datapath
interface mips_mc_controller_if;
    logic [5:0] Op;
    logic [5:0] Function;
    logic       Zero;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic       PCSel;
    logic [1:0] PCSource;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUCtrl;

    // master is the controller: it reads datapath status and drives the strobes
    modport master (
        input  Op, Function, Zero,
        output IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
               RegWrite, RegDst, PCSel, PCSource, ALUSrcB, ALUCtrl
    );

    modport slave (
        output Op, Function, Zero,
        input  IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
               RegWrite, RegDst, PCSel, PCSource, ALUSrcB, ALUCtrl
    );
endinterface

// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multi-cycle MIPS control FSM with illegal-encoding halt and retire counter
module mips_mc_controller #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    mips_mc_controller_if.master dp,
    output logic [3:0]          state,
    output logic                instr_done,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    state_t     cur;
    state_t     nxt;
    logic [3:0] rt_alu;
    logic       funct_ok;
    logic       done_state;
    logic       branch_take;

    always_comb begin
        funct_ok = 1'b1;
        rt_alu   = ALU_ADD;
        case (dp.Function)
            6'b100000: rt_alu = ALU_ADD;
            6'b100010: rt_alu = ALU_SUB;
            6'b100100: rt_alu = ALU_AND;
            6'b100101: rt_alu = ALU_OR;
            6'b100110: rt_alu = ALU_XOR;
            6'b100111: rt_alu = ALU_NOR;
            6'b101010: rt_alu = ALU_SLT;
            default:   funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                case (dp.Op)
                    OP_LW, OP_SW:     nxt = S_MEMADR;
                    OP_RTYPE:         nxt = S_RTEX;
                    OP_BEQ, OP_BNE:   nxt = S_BRANCH;
                    OP_ADDI, OP_SLTI: nxt = S_IMMEX;
                    OP_J:             nxt = S_JUMP;
                    default:          nxt = S_HALT;
                endcase
            end
            S_MEMADR: nxt = (dp.Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  nxt = S_MEMWB;
            S_RTEX:   nxt = funct_ok ? S_RTWB : S_HALT;
            S_IMMEX:  nxt = S_IMMWB;
            S_MEMWB, S_MEMWR, S_RTWB, S_IMMWB, S_BRANCH, S_JUMP: nxt = S_FETCH;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur     <= S_FETCH;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            cur <= nxt;
            if (nxt == S_HALT) begin
                illegal <= 1'b1;
            end
            if (instr_done) begin
                retired <= retired + RETIRE_W'(1);
            end
        end
    end

    assign state = cur;

    always_comb begin
        case (cur)
            S_MEMWB, S_MEMWR, S_RTWB, S_IMMWB, S_BRANCH, S_JUMP: done_state = 1'b1;
            default: done_state = 1'b0;
        endcase
    end

    // Strobes are gated by reset so nothing reaches the datapath while it is held.
    assign instr_done = reset & done_state;

    // Kept apart from the main decode so Zero only feeds PCSel and never the ALU controls.
    assign branch_take = (dp.Op == OP_BEQ) ? dp.Zero : ~dp.Zero;
    assign dp.PCSel    = reset & ((cur == S_FETCH) || (cur == S_JUMP) ||
                                  ((cur == S_BRANCH) && branch_take));

    always_comb begin
        dp.IorD     = 1'b0;
        dp.MemRead  = 1'b0;
        dp.MemWrite = 1'b0;
        dp.MemtoReg = 1'b0;
        dp.IRWrite  = 1'b0;
        dp.ALUSrcA  = 1'b0;
        dp.RegWrite = 1'b0;
        dp.RegDst   = 1'b0;
        dp.PCSource = 2'b00;
        dp.ALUSrcB  = 2'b00;
        dp.ALUCtrl  = ALU_ADD;
        if (reset) begin
            case (cur)
                S_FETCH: begin
                    dp.MemRead = 1'b1;
                    dp.IRWrite = 1'b1;
                    dp.ALUSrcB = 2'b01;
                end
                S_DECODE: begin
                    dp.ALUSrcB = 2'b10;
                end
                S_MEMADR: begin
                    dp.ALUSrcA = 1'b1;
                    dp.ALUSrcB = 2'b10;
                end
                // Address recomputed every memory cycle so ALUOut stays valid for the access.
                S_MEMRD: begin
                    dp.ALUSrcA = 1'b1;
                    dp.ALUSrcB = 2'b10;
                    dp.IorD    = 1'b1;
                    dp.MemRead = 1'b1;
                end
                S_MEMWB: begin
                    dp.ALUSrcA  = 1'b1;
                    dp.ALUSrcB  = 2'b10;
                    dp.IorD     = 1'b1;
                    dp.MemRead  = 1'b1;
                    dp.RegWrite = 1'b1;
                    dp.MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    dp.ALUSrcA  = 1'b1;
                    dp.ALUSrcB  = 2'b10;
                    dp.IorD     = 1'b1;
                    dp.MemWrite = 1'b1;
                end
                S_RTEX: begin
                    dp.ALUSrcA = 1'b1;
                    dp.ALUCtrl = rt_alu;
                end
                S_RTWB: begin
                    dp.ALUSrcA  = 1'b1;
                    dp.ALUCtrl  = rt_alu;
                    dp.RegWrite = 1'b1;
                    dp.RegDst   = 1'b1;
                end
                S_IMMEX: begin
                    dp.ALUSrcA = 1'b1;
                    dp.ALUSrcB = 2'b10;
                    dp.ALUCtrl = (dp.Op == OP_SLTI) ? ALU_SLT : ALU_ADD;
                end
                S_IMMWB: begin
                    dp.ALUSrcA  = 1'b1;
                    dp.ALUSrcB  = 2'b10;
                    dp.ALUCtrl  = (dp.Op == OP_SLTI) ? ALU_SLT : ALU_ADD;
                    dp.RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    dp.ALUSrcA  = 1'b1;
                    dp.ALUCtrl  = ALU_SUB;
                    dp.PCSource = 2'b01;
                end
                S_JUMP: begin
                    dp.PCSource = 2'b10;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb/tb_mips_mc_controller.sv - directed programs on a behavioural multi-cycle datapath around the controller
module tb_mips_mc_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  state;
    logic        instr_done;
    logic        illegal;
    logic [31:0] retired;

    mips_mc_controller_if dp ();

    mips_mc_controller #(.RETIRE_W(32)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .dp         (dp),
        .state      (state),
        .instr_done (instr_done),
        .illegal    (illegal),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // behavioural datapath (word-addressed memory)
    logic [31:0] mem [0:255];
    logic [31:0] init_mem [0:255];
    logic [31:0] rf [0:31];
    logic [31:0] init_rf [0:31];
    logic [31:0] pc, start_pc, ir, a, b, aluout, mdr, jreg;
    logic [31:0] maddr, memdata, srca, srcb, alures;

    assign maddr       = dp.IorD ? aluout : pc;
    assign memdata     = mem[maddr[7:0]];
    assign dp.Op       = ir[31:26];
    assign dp.Function = ir[5:0];
    assign dp.Zero     = (alures == 32'd0);

    always_comb begin
        srca = dp.ALUSrcA ? a : pc;
        case (dp.ALUSrcB)
            2'b00:   srcb = b;
            2'b01:   srcb = 32'd1;
            default: srcb = {{16{ir[15]}}, ir[15:0]};
        endcase
        case (dp.ALUCtrl)
            4'b0000: alures = srca & srcb;
            4'b0001: alures = srca | srcb;
            4'b0010: alures = srca + srcb;
            4'b0110: alures = srca - srcb;
            4'b0111: alures = ($signed(srca) < $signed(srcb)) ? 32'd1 : 32'd0;
            4'b1100: alures = ~(srca | srcb);
            4'b1101: alures = srca ^ srcb;
            default: alures = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (!reset) begin
            pc     <= start_pc;
            ir     <= 32'd0;
            a      <= 32'd0;
            b      <= 32'd0;
            aluout <= 32'd0;
            mdr    <= 32'd0;
            jreg   <= 32'd0;
            for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
            for (int i = 0; i < 32; i++) rf[i] <= init_rf[i];
        end else begin
            if (dp.IRWrite) ir <= memdata;
            a      <= rf[ir[25:21]];
            b      <= rf[ir[20:16]];
            aluout <= alures;
            mdr    <= memdata;
            jreg   <= {6'd0, ir[25:0]};
            if (dp.PCSel) begin
                case (dp.PCSource)
                    2'b00:   pc <= alures;
                    2'b01:   pc <= aluout;
                    default: pc <= jreg;
                endcase
            end
            if (dp.MemWrite) mem[aluout[7:0]] <= b;
            if (dp.RegWrite) rf[dp.RegDst ? ir[15:11] : ir[20:16]] <= dp.MemtoReg ? mdr : aluout;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int         cyc [0:3];
    logic [3:0] alu_ex [0:3];
    logic [3:0] alu_wb [0:3];
    int         ndone, halted, halt_cyc, wr_seen, pcsel_extra, timed_out;

    task automatic clear_init();
        for (int i = 0; i < 256; i++) init_mem[i] = 32'd0;
        for (int i = 0; i < 32; i++) init_rf[i] = 32'd0;
    endtask

    task automatic start(input logic [31:0] spc);
        reset    = 1'b0;
        start_pc = spc;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Runs from the first FETCH cycle until n instructions retire, HALT is seen, or maxc cycles pass.
    task automatic run(input int n, input int maxc);
        int c = 0;
        int tot = 0;
        ndone = 0; halted = 0; halt_cyc = 0; wr_seen = 0; pcsel_extra = 0; timed_out = 0;
        while (ndone < n && halted == 0 && timed_out == 0) begin
            @(negedge clk);
            c++; tot++;
            if (dp.RegWrite || dp.MemWrite) wr_seen++;
            if (dp.PCSel && state != 4'd0) pcsel_extra++;
            if (state == 4'd6) alu_ex[ndone] = dp.ALUCtrl;
            if (state == 4'd7) alu_wb[ndone] = dp.ALUCtrl;
            if (instr_done) begin
                cyc[ndone] = c;
                c = 0;
                ndone++;
            end
            if (state == 4'd15) begin
                halted   = 1;
                halt_cyc = tot;
            end
            if (tot >= maxc && ndone < n && halted == 0) timed_out = 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset values and first FETCH
        clear_init();
        reset    = 1'b0;
        start_pc = 32'd0;
        init_mem[0] = 32'h8C010004;
        init_mem[1] = 32'hAC010008;
        init_mem[4] = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", state, 4'd0);
        check("rst_memread", dp.MemRead, 1'b0);
        check("rst_irwrite", dp.IRWrite, 1'b0);
        check("rst_pcsel", dp.PCSel, 1'b0);
        check("rst_alusrcb", dp.ALUSrcB, 2'b00);
        check("rst_aluctrl", dp.ALUCtrl, 4'b0010);
        check("rst_illegal", illegal, 1'b0);
        check("rst_retired", retired, 32'd0);
        check("rst_done", instr_done, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("fetch_memread", dp.MemRead, 1'b1);
        check("fetch_irwrite", dp.IRWrite, 1'b1);
        check("fetch_pcsel", dp.PCSel, 1'b1);
        check("fetch_alusrcb", dp.ALUSrcB, 2'b01);

        // lw r1,4(r0); sw r1,8(r0)
        run(2, 40);
        check("lwsw_timeout", timed_out, 0);
        check("lw_cycles", cyc[0], 5);
        check("sw_cycles", cyc[1], 4);
        check("lw_r1", rf[1], 32'hDEADBEEF);
        check("sw_mem8", mem[8], 32'hDEADBEEF);
        check("lwsw_retired", retired, 32'd2);

        // add r3,r1,r2; sub r4,r3,r1
        clear_init();
        init_rf[1]  = 32'd5;
        init_rf[2]  = 32'd7;
        init_mem[0] = 32'h00221820;
        init_mem[1] = 32'h00612022;
        start(32'd0);
        run(2, 40);
        check("rt_timeout", timed_out, 0);
        check("add_cycles", cyc[0], 4);
        check("sub_cycles", cyc[1], 4);
        check("add_r3", rf[3], 32'd12);
        check("sub_r4", rf[4], 32'd7);
        check("add_alu_ex", alu_ex[0], 4'b0010);
        check("add_alu_wb", alu_wb[0], 4'b0010);
        check("sub_alu_ex", alu_ex[1], 4'b0110);
        check("sub_alu_wb", alu_wb[1], 4'b0110);
        check("rt_retired", retired, 32'd2);

        // beq r1,r1,+3 at 0x80 (taken)
        clear_init();
        init_rf[1]     = 32'd5;
        init_mem[8'h80] = 32'h10210003;
        start(32'h80);
        run(1, 20);
        check("beq_timeout", timed_out, 0);
        check("beq_cycles", cyc[0], 3);
        check("beq_pc", pc, 32'h84);

        // bne r1,r1,+3 at 0x80 (not taken)
        init_mem[8'h80] = 32'h14210003;
        start(32'h80);
        run(1, 20);
        check("bne_cycles", cyc[0], 3);
        check("bne_pc", pc, 32'h81);

        // j 0x90 at 0x80
        init_mem[8'h80] = 32'h08000090;
        start(32'h80);
        run(1, 20);
        check("j_cycles", cyc[0], 3);
        check("j_pc", pc, 32'h90);
        check("j_retired", retired, 32'd1);

        // illegal opcode 0x3F
        clear_init();
        init_mem[0] = 32'hFC000000;
        start(32'd0);
        run(1, 20);
        check("ilop_halted", halted, 1);
        check("ilop_halt_cycle", halt_cyc, 3);
        check("ilop_no_write", wr_seen, 0);
        check("ilop_no_pcsel", pcsel_extra, 0);
        repeat (3) @(posedge clk);
        #1;
        check("ilop_state", state, 4'd15);
        check("ilop_illegal", illegal, 1'b1);
        check("ilop_retired", retired, 32'd0);
        check("ilop_pc", pc, 32'd1);
        reset = 1'b0;
        #1;
        check("halt_rst_state", state, 4'd0);
        check("halt_rst_illegal", illegal, 1'b0);
        check("halt_rst_memread", dp.MemRead, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("halt_restart_memread", dp.MemRead, 1'b1);
        check("halt_restart_state", state, 4'd0);

        // illegal R-type funct 0x3F
        init_mem[0] = 32'h0000003F;
        start(32'd0);
        run(1, 20);
        check("ilfn_halted", halted, 1);
        check("ilfn_halt_cycle", halt_cyc, 4);
        check("ilfn_no_write", wr_seen, 0);
        check("ilfn_no_pcsel", pcsel_extra, 0);
        check("ilfn_illegal", illegal, 1'b1);
        check("ilfn_state", state, 4'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
